// File: rtl/pmix_code_ctrl.sv
// pmix_code_ctrl: bang-bang CDR phase controller driving the 11-bit phase-mixer code.
// Collects early/late votes, takes a majority decision every VOTE_LEN votes and
// steps Code modulo 2048. Define FREQ_TRACK_EN to enable the integral (frequency) path;
// without it freq_acc reads 0 and the loop is first-order only.
module pmix_code_ctrl #(
    parameter int unsigned VOTE_LEN  = 8,
    parameter int unsigned KP        = 1,
    parameter int unsigned KI_SHIFT  = 4,
    parameter int unsigned INT_W     = 12,
    parameter logic [10:0] CODE_INIT = 11'h000
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             vote_valid,
    output logic             vote_ready,
    input  logic             early,
    input  logic             late,
    input  logic             hold,
    output logic [10:0]      Code,
    output logic             code_valid,
    output logic [INT_W-1:0] freq_acc
);

    localparam int unsigned CNT_W  = $clog2(VOTE_LEN);
    localparam int unsigned SUM_W  = $clog2(VOTE_LEN) + 2;
    localparam int unsigned STEP_W = 9;
    localparam int          STEP_MAX = 255;
    localparam int          KP_S     = int'(KP);

    typedef enum logic [1:0] {ACCUM, DECIDE, UPDATE} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic signed [SUM_W-1:0]  sum, sum_next, sum_vote, vote_delta;
    logic signed [1:0]        dir, dir_next;
    logic signed [STEP_W-1:0] step, step_next;
    logic signed [INT_W-1:0]  facc_q, facc_next;
    logic signed [31:0]       step_wide;
    logic                     accept;

`ifdef FREQ_TRACK_EN
    localparam int FACC_MAX = int'((32'd1 << (INT_W - 1)) - 32'd1);
    logic signed [31:0] facc_wide;
`endif

    // Votes are taken only in ACCUM, never while held or in reset
    assign vote_ready = !rst && (state == ACCUM) && !hold;
    assign accept     = vote_valid && vote_ready;
    assign freq_acc   = facc_q;

    // Signed contribution of the current vote (both or neither counts as zero)
    always_comb begin
        vote_delta = '0;
        if (early && !late) begin
            vote_delta = SUM_W'(1);
        end else if (late && !early) begin
            vote_delta = '1;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sum_next   = sum;
        dir_next   = dir;
        step_next  = step;
        facc_next  = facc_q;
        sum_vote   = sum + vote_delta;
        step_wide  = '0;
`ifdef FREQ_TRACK_EN
        facc_wide  = '0;
`endif
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (32'(cnt) + 32'd1 == VOTE_LEN) begin
                        if (sum_vote == '0) begin
                            dir_next = 2'b00;
                        end else if (sum_vote[SUM_W-1]) begin
                            dir_next = 2'b11;
                        end else begin
                            dir_next = 2'b01;
                        end
                        cnt_next   = '0;
                        sum_next   = '0;
                        state_next = DECIDE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                        sum_next = sum_vote;
                    end
                end
            end
            DECIDE: begin
`ifdef FREQ_TRACK_EN
                facc_wide = 32'(facc_q) + 32'(dir);
                if (facc_wide > FACC_MAX) begin
                    facc_wide = FACC_MAX;
                end else if (facc_wide < -FACC_MAX) begin
                    facc_wide = -FACC_MAX;
                end
                facc_next = INT_W'(facc_wide);
`endif
                step_wide = 32'(dir) * KP_S + (32'(facc_next) >>> KI_SHIFT);
                if (step_wide > STEP_MAX) begin
                    step_wide = STEP_MAX;
                end else if (step_wide < -STEP_MAX) begin
                    step_wide = -STEP_MAX;
                end
                step_next  = STEP_W'(step_wide);
                state_next = UPDATE;
            end
            UPDATE: begin
                state_next = ACCUM;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State and vote accumulator registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ACCUM;
            cnt   <= '0;
            sum   <= '0;
            dir   <= '0;
            step  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sum   <= sum_next;
            dir   <= dir_next;
            step  <= step_next;
        end
    end

`ifdef FREQ_TRACK_EN
    // Frequency accumulator integrates each decision direction
    always_ff @(posedge CLK) begin
        if (rst) begin
            facc_q <= '0;
        end else begin
            facc_q <= facc_next;
        end
    end
`else
    assign facc_q = '0;
`endif

    // Phase code register; wraps modulo 2048, pulses code_valid on every update
    always_ff @(posedge CLK) begin
        if (rst) begin
            Code       <= CODE_INIT;
            code_valid <= 1'b0;
        end else begin
            code_valid <= (state == UPDATE);
            if (state == UPDATE) begin
                Code <= Code + 11'(step);
            end
        end
    end

endmodule

// File: tb/tb_pmix_code_ctrl.sv
// Self-checking bench for pmix_code_ctrl: table of vote patterns with hand-derived
// decision directions, a reference model feeding a scoreboard of expected updates,
// and hand sequences for hold, wrap and reset-abort behaviour.
module tb_pmix_code_ctrl;

    localparam int VOTE_LEN = 8;
    localparam int KP       = 1;
    localparam int KI_SHIFT = 2;
    localparam int INT_W    = 12;
    localparam logic [10:0] CODE_INIT = 11'h000;
    localparam int FMAX     = (1 << (INT_W - 1)) - 1;

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             vote_valid = 1'b0;
    logic             early = 1'b0;
    logic             late = 1'b0;
    logic             hold = 1'b0;
    logic             vote_ready;
    logic [10:0]      Code;
    logic             code_valid;
    logic [INT_W-1:0] freq_acc;

    pmix_code_ctrl #(
        .VOTE_LEN (VOTE_LEN),
        .KP       (KP),
        .KI_SHIFT (KI_SHIFT),
        .INT_W    (INT_W),
        .CODE_INIT(CODE_INIT)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .vote_valid(vote_valid),
        .vote_ready(vote_ready),
        .early     (early),
        .late      (late),
        .hold      (hold),
        .Code      (Code),
        .code_valid(code_valid),
        .freq_acc  (freq_acc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] em;
        logic [7:0] lm;
        int         d;
    } vec_t;

    typedef struct {
        int code;
        int facc;
        int cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_code = 0;
    int   m_facc = 0;
    logic rst_q;
    logic [10:0] prev_code;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
        end
    endfunction

    // Reference model: apply one decision and queue the expected update
    function automatic void push_exp(input int d, input int acc_cyc);
        int   st;
        exp_t e;
`ifdef FREQ_TRACK_EN
        m_facc = m_facc + d;
        if (m_facc > FMAX) m_facc = FMAX;
        if (m_facc < -FMAX) m_facc = -FMAX;
`endif
        st = d * KP + (m_facc >>> KI_SHIFT);
        if (st > 255) st = 255;
        if (st < -255) st = -255;
        m_code = (m_code + st) & 32'h7FF;
        e.code = m_code;
        e.facc = m_facc;
        e.cyc  = acc_cyc + 3;
        sb.push_back(e);
    endfunction

    // Scoreboard: compare every code_valid pulse, and Code stability otherwise
    always @(negedge CLK) begin : mon
        exp_t e;
        if (rst_q === 1'b0) begin
            if (code_valid === 1'b1) begin
                chk("pending_at_code_valid", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cv_code", 32'(Code), e.code);
                    chk("cv_freq_acc", 32'($signed(freq_acc)), e.facc);
                    chk("cv_cycle", cyc, e.cyc);
                end
            end else begin
                chk("code_stable", 32'(Code), 32'(prev_code));
            end
        end
        prev_code = Code;
    end

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1; vote_valid = 1'b0; hold = 1'b0; early = 1'b0; late = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_code", 32'(Code), 32'(CODE_INIT));
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_vote_ready", 32'(vote_ready), 32'd0);
        chk("rst_freq_acc", 32'($signed(freq_acc)), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(vote_ready), 32'd1);
        m_code = int'(CODE_INIT);
        m_facc = 0;
        sb.delete();
    endtask

    // Present one vote and wait (bounded) until it is accepted
    task automatic send_vote(input logic e, input logic l, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge CLK);
        vote_valid = 1'b1; early = e; late = l;
        #1;
        while (vote_ready !== 1'b1 && waited < 100) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        chk("vote_accept_wait", 32'(vote_ready === 1'b1), 32'd1);
        acc_cyc = cyc;
        @(posedge CLK);
        #1;
        vote_valid = 1'b0; early = 1'b0; late = 1'b0;
    endtask

    // One full decision: VOTE_LEN votes, queue expectation, check ready gap
    task automatic decide(input logic [7:0] em, input logic [7:0] lm, input int d);
        int c;
        for (int i = 0; i < VOTE_LEN; i++) send_vote(em[i], lm[i], c);
        push_exp(d, c);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("vote_ready_n+%0d", k), 32'(vote_ready), 32'(k == 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        tbl[0] = '{8'hFF, 8'h00,  1};
        tbl[1] = '{8'h00, 8'hFF, -1};
        tbl[2] = '{8'h55, 8'hAA,  0};
        tbl[3] = '{8'hFF, 8'hFF,  0};
        tbl[4] = '{8'hE0, 8'h03,  1};
        tbl[5] = '{8'h01, 8'h06, -1};
        tbl[6] = '{8'hC1, 8'hC0,  1};
        tbl[7] = '{8'h0F, 8'h0F,  0};

        // Basic +1 step and latency
        do_reset();
        decide(8'hFF, 8'h00, 1);
        chk("t1_code", 32'(Code), 32'h001);

        // Wrap below zero and back
        do_reset();
        decide(8'h00, 8'hFF, -1);
`ifdef FREQ_TRACK_EN
        chk("t2_wrap_down", 32'(Code), 32'h7FE);
`else
        chk("t2_wrap_down", 32'(Code), 32'h7FF);
`endif
        decide(8'hFF, 8'h00, 1);
`ifdef FREQ_TRACK_EN
        chk("t2_wrap_up", 32'(Code), 32'h7FF);
`else
        chk("t2_wrap_up", 32'(Code), 32'h000);
`endif

        // Balanced and both-asserted votes leave Code unchanged
        do_reset();
        decide(8'h55, 8'hAA, 0);
        decide(8'hFF, 8'hFF, 0);
        decide(8'h0F, 8'h0F, 0);
        chk("t3_code", 32'(Code), 32'h000);

        // Four early decisions exercise the integral path
        do_reset();
        for (int i = 0; i < 4; i++) decide(8'hFF, 8'h00, 1);
`ifdef FREQ_TRACK_EN
        chk("t4_code", 32'(Code), 32'h005);
        chk("t4_freq_acc", 32'($signed(freq_acc)), 32'd4);
`else
        chk("t4_code", 32'(Code), 32'h004);
        chk("t4_freq_acc", 32'($signed(freq_acc)), 32'd0);
`endif

        // Table of vote patterns through the scoreboard
        do_reset();
        for (int i = 0; i < 8; i++) decide(tbl[i].em, tbl[i].lm, tbl[i].d);

        // Hold retains a partial count and blocks votes
        do_reset();
        for (int i = 0; i < 5; i++) send_vote(1'b1, 1'b0, c);
        @(negedge CLK);
        hold = 1'b1; vote_valid = 1'b1; early = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("hold_vote_ready", 32'(vote_ready), 32'd0);
            @(negedge CLK);
        end
        hold = 1'b0; vote_valid = 1'b0; early = 1'b0;
        for (int i = 0; i < 3; i++) send_vote(1'b1, 1'b0, c);
        push_exp(1, c);
        repeat (3) @(negedge CLK);
        #1;
        chk("t5_code", 32'(Code), 32'h001);

        // Hold raised mid-decision: update still completes
        for (int i = 0; i < VOTE_LEN; i++) send_vote(1'b1, 1'b0, c);
        push_exp(1, c);
        @(negedge CLK);
        hold = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("inflight_code_valid", 32'(code_valid), 32'd1);
        chk("inflight_vote_ready", 32'(vote_ready), 32'd0);
        chk("inflight_code", 32'(Code), 32'h002);
        @(negedge CLK);
        hold = 1'b0;

        // Reset during UPDATE aborts the update
        do_reset();
        decide(8'hFF, 8'h00, 1);
        decide(8'hFF, 8'h00, 1);
        for (int i = 0; i < VOTE_LEN; i++) send_vote(1'b0, 1'b1, c);
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        #1;
        chk("abort_code", 32'(Code), 32'(CODE_INIT));
        chk("abort_code_valid", 32'(code_valid), 32'd0);
        chk("abort_freq_acc", 32'($signed(freq_acc)), 32'd0);
        chk("abort_vote_ready", 32'(vote_ready), 32'd0);
        rst = 1'b0;
        m_code = int'(CODE_INIT);
        m_facc = 0;
        sb.delete();
        decide(8'hFF, 8'h00, 1);
        chk("after_abort_code", 32'(Code), 32'h001);

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
